// File: rtl/amp_resp_pkg.sv
// amp_resp_pkg: shared width, field positions, sync depth and FSM states for amp_spi_responder
package amp_resp_pkg;
  localparam int DEF_WIDTH   = 8;
  localparam int GAIN_A_LSB  = 0;
  localparam int GAIN_B_LSB  = 4;
  localparam int SYNC_STAGES = 2;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} resp_state_t;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-FF synchronizer with rise/fall detect against one extra history register
module sync_edge
  import amp_resp_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  // Synchronizer chain plus the previous synchronized value for edge detection
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;
endmodule

// File: rtl/amp_spi_responder.sv
// amp_spi_responder: SPI responder for the preamp gain port; AMP_RESP_ECHO_EN enables the amp_dout echo
module amp_spi_responder
  import amp_resp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic       CLK50MHZ,
  input  logic       RST_N,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       amp_cs,
  input  logic       amp_shdn,
  output logic       amp_dout,
  output logic [3:0] gain_a,
  output logic [3:0] gain_b,
  output logic       gain_valid,
  output logic       frame_err,
  output logic [3:0] bit_count
);
  resp_state_t      state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] gain_q, gain_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             sck_rise, sck_fall, sck_s_unused;
  logic             mosi_s, mosi_rise_unused, mosi_fall_unused;
  logic             cs_rise, cs_fall, cs_s_unused;
`ifdef AMP_RESP_ECHO_EN
  logic             dout_q, dout_d;
`else
  logic             sck_fall_unused;
`endif

  sync_edge u_sck (
    .clk_i (CLK50MHZ),
    .rst_ni(RST_N),
    .d_i   (spi_sck),
    .q_o   (sck_s_unused),
    .rise_o(sck_rise),
    .fall_o(sck_fall)
  );

  sync_edge u_mosi (
    .clk_i (CLK50MHZ),
    .rst_ni(RST_N),
    .d_i   (spi_mosi),
    .q_o   (mosi_s),
    .rise_o(mosi_rise_unused),
    .fall_o(mosi_fall_unused)
  );

  sync_edge u_cs (
    .clk_i (CLK50MHZ),
    .rst_ni(RST_N),
    .d_i   (amp_cs),
    .q_o   (cs_s_unused),
    .rise_o(cs_rise),
    .fall_o(cs_fall)
  );

  // Next-state logic; a cs rise takes priority over any coincident sck edge
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    gain_d  = gain_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
`ifdef AMP_RESP_ECHO_EN
    dout_d  = dout_q;
`endif
    if (amp_shdn) begin
      state_d = IDLE;
      gain_d  = '0;
      cnt_d   = '0;
`ifdef AMP_RESP_ECHO_EN
      dout_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (cs_fall) begin
          state_d = SHIFT;
          sr_d    = gain_q;
          cnt_d   = '0;
`ifdef AMP_RESP_ECHO_EN
          dout_d  = gain_q[WIDTH-1];
`endif
        end
        SHIFT: if (cs_rise) begin
          state_d = int'(cnt_q) >= WIDTH ? COMMIT : IDLE;
          err_d   = int'(cnt_q) < WIDTH;
        end else begin
          if (sck_rise) begin
            sr_d  = {sr_q[WIDTH-2:0], mosi_s};
            cnt_d = cnt_q == 4'hF ? cnt_q : cnt_q + 4'd1;
          end
`ifdef AMP_RESP_ECHO_EN
          if (sck_fall) dout_d = sr_q[WIDTH-1];
`endif
        end
        COMMIT: begin
          gain_d  = sr_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, shift register, committed gain, bit counter and pulse registers
  always_ff @(posedge CLK50MHZ or negedge RST_N)
    if (!RST_N) begin
      state_q <= IDLE;
      sr_q    <= '0;
      gain_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      gain_q  <= gain_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end

`ifdef AMP_RESP_ECHO_EN
  // Echo bit register, driven from the cs fall and each sck fall
  always_ff @(posedge CLK50MHZ or negedge RST_N)
    if (!RST_N) dout_q <= 1'b0;
    else dout_q <= dout_d;
  assign amp_dout = dout_q;
`else
  assign sck_fall_unused = sck_fall;
  assign amp_dout = 1'b0;
`endif

  assign gain_a     = gain_q[GAIN_A_LSB +: 4];
  assign gain_b     = gain_q[GAIN_B_LSB +: 4];
  assign gain_valid = valid_q;
  assign frame_err  = err_q;
  assign bit_count  = cnt_q;
endmodule

// File: tb/tb_amp_spi_responder.sv
// tb_amp_spi_responder: directed plus randomized frames checked against a frame-level gain/echo model
module tb_amp_spi_responder;
  localparam int W = 8;
`ifdef AMP_RESP_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, sck, mosi, cs, shdn;
  logic       dout, valid, err;
  logic [3:0] ga, gb, cnt;
  logic [W-1:0] exp_gain;
  int checks = 0;
  int fails = 0;

  amp_spi_responder dut (
    .CLK50MHZ  (clk),
    .RST_N     (rst_n),
    .spi_sck   (sck),
    .spi_mosi  (mosi),
    .amp_cs    (cs),
    .amp_shdn  (shdn),
    .amp_dout  (dout),
    .gain_a    (ga),
    .gain_b    (gb),
    .gain_valid(valid),
    .frame_err (err),
    .bit_count (cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic pulse(input bit b, input int half);
    mosi = b;
    cyc(half);
    sck = 1'b1;
    cyc(half);
    sck = 1'b0;
  endtask

  // Send the n low bits of 'bits' MSB first; optionally raise cs together with the last sck rise
  task automatic frame(input logic [15:0] bits, input int n, input int half, input bit simult);
    logic [W-1:0] prior, nv;
    bit stream[$];
    int ns;
    bit ok;
    prior = exp_gain;
    ns = simult ? n - 1 : n;
    ok = ns >= W;
    nv = ok ? W'(bits >> (n - ns)) : prior;
    for (int i = W - 1; i >= 0; i--) stream.push_back(prior[i]);
    for (int i = 0; i < n; i++) stream.push_back(bits[n-1-i]);
    cs = 1'b0;
    cyc(4);
    for (int i = 0; i < n; i++) begin
      mosi = bits[n-1-i];
      cyc(half);
      chk("echo", {15'd0, dout}, {15'd0, ECHO ? stream[i] : 1'b0});
      sck = 1'b1;
      if (simult && i == n - 1) begin
        cs = 1'b1;
      end else begin
        cyc(half);
        sck = 1'b0;
      end
    end
    if (!simult || n == 0) begin
      cyc(half);
      cs = 1'b1;
    end
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      chk("gain_valid", {15'd0, valid}, {15'd0, ok && k == 4});
      chk("frame_err", {15'd0, err}, {15'd0, !ok && k == 3});
      if (k == 3) chk("gain_pre", {8'd0, gb, ga}, {8'd0, prior});
      if (k == 4) chk("gain_post", {8'd0, gb, ga}, {8'd0, nv});
    end
    chk("bit_count", {12'd0, cnt}, 16'(ns > 15 ? 15 : ns));
    sck = 1'b0;
    exp_gain = nv;
    cyc(2);
  endtask

  initial begin
    int n, half;
    bit sim;
    rst_n = 1'b0;
    sck = 1'b0;
    mosi = 1'b0;
    cs = 1'b1;
    shdn = 1'b0;
    exp_gain = '0;
    #1;
    chk("rst_gain", {8'd0, gb, ga}, 16'd0);
    chk("rst_dout", {15'd0, dout}, 16'd0);
    chk("rst_pulses", {14'd0, valid, err}, 16'd0);
    chk("rst_cnt", {12'd0, cnt}, 16'd0);
    cyc(3);
    rst_n = 1'b1;
    cyc(5);
    chk("idle_gain", {8'd0, gb, ga}, 16'd0);
    // basic commit, echo, 9-bit marker, short frame, saturation, simultaneous cs/sck
    frame(16'h0035, 8, 3, 1'b0);
    frame(16'h009A, 8, 3, 1'b0);
    frame(16'h0142, 9, 4, 1'b0);
    frame(16'h0016, 5, 3, 1'b0);
    frame(16'hA53C, 16, 3, 1'b0);
    frame(16'h0187, 9, 3, 1'b1);
    // shutdown mid-frame aborts silently and clears the gain
    cs = 1'b0;
    cyc(4);
    for (int i = 0; i < 4; i++) pulse(i[0], 3);
    shdn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk("shdn_pulses", {14'd0, valid, err}, 16'd0);
    end
    chk("shdn_gain", {8'd0, gb, ga}, 16'd0);
    chk("shdn_dout", {15'd0, dout}, 16'd0);
    for (int i = 0; i < 6; i++) pulse(1'b1, 3);
    cs = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      chk("shdn_cs_pulses", {14'd0, valid, err}, 16'd0);
    end
    shdn = 1'b0;
    exp_gain = '0;
    cyc(3);
    // reset mid-frame, then the remainder of that frame is ignored
    frame(16'h00FE, 8, 3, 1'b0);
    cs = 1'b0;
    cyc(4);
    for (int i = 0; i < 3; i++) pulse(1'b1, 3);
    cyc(3);
    rst_n = 1'b0;
    #1;
    chk("arst_gain", {8'd0, gb, ga}, 16'd0);
    chk("arst_dout", {15'd0, dout}, 16'd0);
    chk("arst_pulses", {14'd0, valid, err}, 16'd0);
    chk("arst_cnt", {12'd0, cnt}, 16'd0);
    exp_gain = '0;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    for (int i = 0; i < 8; i++) pulse(1'b1, 3);
    cyc(3);
    cs = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      chk("post_rst_pulses", {14'd0, valid, err}, 16'd0);
    end
    chk("post_rst_gain", {8'd0, gb, ga}, 16'd0);
    cyc(3);
    // randomized frames
    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(0, 12);
      half = $urandom_range(3, 5);
      sim = n >= 1 && $urandom_range(0, 3) == 0;
      frame(16'($urandom), n, half, sim);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule

// File: doc/amp_spi_responder.md
# amp_spi_responder

Synthesizable SPI responder model of the programmable preamplifier's serial port, for the bench and on-chip loopback of the amplifier gain path. It oversamples the SPI pins on the system clock, shifts in the gain word while chip-select is low, echoes the previous gain word on `amp_dout` as the device does, and commits the new A/B gain nibbles when chip-select rises. It sits opposite the amplifier SPI initiator on the same `spi_sck`, `spi_mosi`, `amp_cs`, `amp_shdn` and `amp_dout` wires.

## Interface
- `WIDTH`, 8: gain register bits; `{gain_b, gain_a}`, with `gain_b` as the upper nibble.
- `CLK50MHZ` in 1: system clock. All logic is clocked on the rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `spi_sck` in 1: SPI clock from the initiator. It is asynchronous to `CLK50MHZ` and is synchronized internally.
- `spi_mosi` in 1: serial data, MSB first, sampled on `spi_sck` rising.
- `amp_cs` in 1: chip select, active-low.
- `amp_shdn` in 1: shutdown, active-high.
- `amp_dout` out 1: echo of the previous register contents, MSB first, updated on `spi_sck` falling.
- `gain_a` out 4: committed channel-A gain.
- `gain_b` out 4: committed channel-B gain.
- `gain_valid` out 1: one-cycle pulse when a new gain is committed.
- `frame_err` out 1: one-cycle pulse when a frame is rejected.
- `bit_count` out 4: debug count of bits in the current frame; saturates at 15.

## Operation
- **Synchronizers:** `spi_sck`, `spi_mosi` and `amp_cs` each pass through a 2-FF synchronizer. Edges are detected on the synchronized copies: the current value is compared with a third register.
- **States:** `IDLE`, `SHIFT`, `COMMIT`.
- **IDLE:**
  - On a synchronized `amp_cs` fall: load `sr <= {gain_b, gain_a}`, set `amp_dout <= gain_b[3]`, set `bit_count <= 0`, go to `SHIFT`.
  - `sck` edges are ignored while `cs` is high.
- **SHIFT, `sck` rise:**
  - `sr <= {sr[WIDTH-2:0], mosi_s}`.
  - `bit_count` increments and saturates at 15.
- **SHIFT, `sck` fall:** `amp_dout <= sr[WIDTH-1]`.
- **SHIFT, `cs` rise:**
  - If `bit_count >= WIDTH`, go to `COMMIT`. Extra leading bits have already been shifted out, so the last `WIDTH` bits are kept (a 9-bit frame with a leading marker bit is accepted).
  - Otherwise pulse `frame_err` and go to `IDLE`. Gains are unchanged.
- **COMMIT:**
  - `{gain_b, gain_a} <= sr`.
  - Pulse `gain_valid`.
  - Go to `IDLE`.
- **Simultaneous events:** a `cs` rise in the same cycle as an `sck` edge is handled as the `cs` rise only; the `sck` edge is dropped.
- **Shutdown:** while `amp_shdn` is 1:
  - state is forced to `IDLE`;
  - gains are cleared to 0;
  - `amp_dout` is 0;
  - no pulses are issued.

  Frames in progress are aborted silently.
- **Reset:** `RST_N` low clears all state asynchronously, including mid-frame. A frame in progress when reset releases is ignored until the next `cs` fall.

## Timing
- **Reset values:**
  - `gain_a = 0`, `gain_b = 0`.
  - `amp_dout = 0`.
  - `gain_valid = 0`, `frame_err = 0`.
  - `bit_count = 0`.
  - state = `IDLE`.
- **Edge detection:** an internal edge acts 3 `CLK50MHZ` cycles after the pin edge.
- **Output latency:**
  - `amp_dout` changes 3 cycles after an `spi_sck` fall.
  - `gain_valid` asserts 4 cycles after an `amp_cs` rise, and `gain_*` update in that same cycle.
  - `frame_err` asserts 3 cycles after an `amp_cs` rise.
- **Minimum SPI timing:**
  - each `spi_sck` high and low phase must be at least 3 `CLK50MHZ` cycles (a `ModClk` `DIV` of 6 or more meets this);
  - `cs` high between frames must be at least 3 cycles.

## Configuration
- `AMP_RESP_ECHO_EN` defined: `amp_dout` echoes the previous register as described above.
- `AMP_RESP_ECHO_EN` undefined:
  - `amp_dout` is tied to 0;
  - the `sck`-fall logic is removed;
  - all other behaviour is identical.

## Structure
- **Package `amp_resp_pkg`:**
  - `WIDTH` default;
  - state enum `resp_state_t` with values `IDLE`, `SHIFT`, `COMMIT`;
  - nibble field positions `GAIN_A_LSB = 0`, `GAIN_B_LSB = 4`;
  - synchronizer depth `SYNC_STAGES = 2`.
- **Sub-module `sync_edge`:** 2-FF synchronizer with rise/fall detect. It is instantiated three times, for `sck`, `mosi` and `cs`; rise/fall outputs of the `mosi` instance are unused.

## Test plan
- **Basic commit:** reset, then an 8-bit frame `0x35` at sck divide 6 -> `gain_b = 3`, `gain_a = 5`, one `gain_valid` pulse 4 cycles after `cs` rise.
- **Echo:** with gain `0x35` committed, send `0x9A` -> `amp_dout` carries `0,0,1,1,0,1,0,1` on successive `sck` falls; gain becomes `0x9A`.
- **9-bit frame with marker:** send `1_0x42` -> gain `0x42`, no `frame_err`.
- **Short frame:** send 5 bits then raise `cs` -> one `frame_err` pulse, gain unchanged at its prior value, no `gain_valid`.
- **Shutdown and reset:**
  - assert `amp_shdn` mid-frame -> gain 0, `amp_dout = 0`, no pulses;
  - pull `RST_N` low mid-frame -> all outputs at reset values within the same cycle.
- **Simultaneous events:** `cs` rise coincident with `sck` rise after 8 bits -> the 9th bit is not shifted and the 8-bit value is committed.
